vga_tile_scanner: RTL
=====================

Name: vga_tile_scanner

Overview:
- Downstream consumer of the 128-byte RAM bus byte selector: generates 640x480@60 VGA timing and drives the 8-bit byte index.
- Samples the selected byte as an RRRGGGBB tile colour and drives sync and RGB outputs.
- The screen is a 16x8 grid of tiles; byte n covers tile row n/16, column n%16.
- Sits between the byte selector and the board VGA connector.

Parameters:
CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); must be >= 2
H_VISIBLE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
TILE_W, 40, tile width in pixels; TILE_W*16 must equal H_VISIBLE
TILE_H, 60, tile height in lines; TILE_H*8 must equal V_VISIBLE

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
pix_byte  input  8  byte returned by the selector for the current idx (combinational path)
idx  output  8  byte index into the 128-byte bus; bit 7 always 0
hsync  output  1  horizontal sync, active-low
vsync  output  1  vertical sync, active-low
red  output  3  pix_byte[7:5] when visible, else 0
green  output  3  pix_byte[4:2] when visible, else 0
blue  output  2  pix_byte[1:0] when visible, else 0
frame_start  output  1  one-clk pulse at each frame wrap

Behaviour:
- All state is registered on posedge clk; rst is synchronous and active-high.
- Reset values: div_cnt=0, h_cnt=0, v_cnt=0, tile counters=0, idx=0, hsync=1, vsync=1, RGB=0, frame_start=0. Pipeline registers: active=0, hs=1, vs=1.
- Reset asserted mid-frame aborts the frame. Timing restarts at (0,0) on the first clk after rst deasserts.
- Pixel enable:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - pix_en=1 on the clk where div_cnt==CLK_DIV-1.
  - All counters and pipeline stages advance only on pix_en.
- Counters:
  - H_TOTAL=800 and V_TOTAL=525 with defaults.
  - h_cnt counts 0..H_TOTAL-1. At wrap, h_cnt returns to 0 and v_cnt increments.
  - v_cnt wraps 0..V_TOTAL-1.
- Tile counters (no dividers):
  - tx_sub counts 0..TILE_W-1 across visible pixels; tile_x (4 bits) increments when tx_sub wraps.
  - Both clear at h_cnt wrap.
  - ty_sub and tile_y (3 bits) work the same way per visible line, and clear at v_cnt wrap.
- Stage 1 (on pix_en, from the current counter values):
  - s1_active = (h_cnt<H_VISIBLE && v_cnt<V_VISIBLE).
  - idx = s1_active ? {1'b0, tile_y, tile_x} : 0.
  - s1_hs = ~(H_VISIBLE+H_FP <= h_cnt < H_VISIBLE+H_FP+H_SYNC).
  - s1_vs is formed the same way on v_cnt.
- Stage 2 (on pix_en):
  - {red,green,blue} = s1_active ? pix_byte split : 0.
  - hsync=s1_hs, vsync=s1_vs.
  - pix_byte must be settled within one pix_en period of idx changing; the selector is combinational, so this holds.
- Latency: counter position (h,v) appears on RGB/sync outputs 2 pix_en after the counters hold (h,v). hsync and RGB stay mutually aligned.
- Blanking: RGB forced to 0 regardless of pix_byte. idx is held at 0.
- frame_start=1 for exactly one clk, on the pix_en where h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1; 0 otherwise. It never fires during reset.
- Simultaneous line wrap and tile wrap: line wrap wins; tile_x and tx_sub clear.

Test Plan:
- Reset then free-run: hsync period = 3200 clk; low width = 384 clk. vsync low for exactly 2 lines (6400 clk); vsync period = 1,680,000 clk.
- Counter-driven pix_byte model (byte n = n): first visible pixel shows RGB from byte 0. Pixel 40 of line 0 uses idx=1. Line 60, pixel 600 uses idx=31. Pixel 639 of line 479 uses idx=127. No idx exceeds 127.
- pix_byte forced to 8'hFF: RGB=0 for every pixel with h>=640 or v>=480. RGB=(7,7,3) for all visible pixels, with 640 pixels per visible line.
- frame_start: exactly one pulse per 1,680,000 clk. Pulse occurs 1 clk-aligned with the pix_en that returns counters to (0,0).
- Assert rst for 3 clk mid-line (h=300, v=200): outputs go to reset values on the next clk. After release, the first hsync falling edge occurs (656+2)*4 clk later.
- CLK_DIV=2 instance: hsync period = 1600 clk; latency and tile mapping unchanged in pixel units.

Source files
------------

// File: rtl/vga_tile_scanner.sv
// VGA timing generator that walks a 16x8 tile grid and turns the selected
// RRRGGGBB byte into colour. Two pix_en stages: index/sync decode, then colour.
module vga_tile_scanner #(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int TILE_W    = 40,
    parameter int TILE_H    = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pix_byte,
    output logic [7:0] idx,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [1:0] blue,
    output logic       frame_start
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int DW  = $clog2(CLK_DIV);
    localparam int HW  = $clog2(H_TOTAL);
    localparam int VW  = $clog2(V_TOTAL);
    localparam int TXW = (TILE_W > 1) ? $clog2(TILE_W) : 1;
    localparam int TYW = (TILE_H > 1) ? $clog2(TILE_H) : 1;

    localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0]  H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0]  V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0]  H_VIS    = HW'(H_VISIBLE);
    localparam logic [VW-1:0]  V_VIS    = VW'(V_VISIBLE);
    localparam logic [HW-1:0]  HS_START = HW'(H_VISIBLE + H_FP);
    localparam logic [HW-1:0]  HS_END   = HW'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [VW-1:0]  VS_START = VW'(V_VISIBLE + V_FP);
    localparam logic [VW-1:0]  VS_END   = VW'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [TXW-1:0] TX_LAST  = TXW'(TILE_W - 1);
    localparam logic [TYW-1:0] TY_LAST  = TYW'(TILE_H - 1);

    logic [DW-1:0]  div_cnt;
    logic [HW-1:0]  h_cnt;
    logic [VW-1:0]  v_cnt;
    logic [TXW-1:0] tx_sub;
    logic [TYW-1:0] ty_sub;
    logic [3:0]     tile_x;
    logic [2:0]     tile_y;
    logic           s1_active, s1_hs, s1_vs;

    logic pix_en, line_end, frame_end, h_vis, v_vis;

    assign pix_en    = (div_cnt == DIV_LAST);
    assign line_end  = (h_cnt == H_LAST);
    assign frame_end = line_end && (v_cnt == V_LAST);
    assign h_vis     = (h_cnt < H_VIS);
    assign v_vis     = (v_cnt < V_VIS);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt     <= '0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            tx_sub      <= '0;
            ty_sub      <= '0;
            tile_x      <= '0;
            tile_y      <= '0;
            s1_active   <= 1'b0;
            s1_hs       <= 1'b1;
            s1_vs       <= 1'b1;
            idx         <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= pix_en ? '0 : div_cnt + 1'b1;
            frame_start <= pix_en && frame_end;
            if (pix_en) begin
                h_cnt <= line_end ? '0 : h_cnt + 1'b1;
                if (line_end)
                    v_cnt <= frame_end ? '0 : v_cnt + 1'b1;

                // Line wrap takes priority over a tile wrap on the same pixel.
                if (line_end) begin
                    tx_sub <= '0;
                    tile_x <= '0;
                end else if (h_vis) begin
                    if (tx_sub == TX_LAST) begin
                        tx_sub <= '0;
                        tile_x <= tile_x + 1'b1;
                    end else begin
                        tx_sub <= tx_sub + 1'b1;
                    end
                end

                if (frame_end) begin
                    ty_sub <= '0;
                    tile_y <= '0;
                end else if (line_end && v_vis) begin
                    if (ty_sub == TY_LAST) begin
                        ty_sub <= '0;
                        tile_y <= tile_y + 1'b1;
                    end else begin
                        ty_sub <= ty_sub + 1'b1;
                    end
                end

                s1_active <= h_vis && v_vis;
                idx       <= (h_vis && v_vis) ? {1'b0, tile_y, tile_x} : 8'd0;
                s1_hs     <= !((h_cnt >= HS_START) && (h_cnt < HS_END));
                s1_vs     <= !((v_cnt >= VS_START) && (v_cnt < VS_END));

                // pix_byte here already reflects the idx registered last pix_en.
                {red, green, blue} <= s1_active ? pix_byte : 8'd0;
                hsync <= s1_hs;
                vsync <= s1_vs;
            end
        end
    end
endmodule
